// File: rtl/irq_ctrl.sv
// irq_ctrl: NSRC-channel interrupt controller with per-channel enable, edge/level mode,
// fixed priority (index 0 highest), in-service tracking and optional nesting.
module irq_ctrl #(
  parameter int NSRC = 8,
  parameter int SYNC = 2,
  parameter int NEST = 1,
  parameter logic [NSRC-1:0] MODE_RST = '1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [NSRC-1:0] src,
  input  logic [2:0]  ioadr,
  input  logic        wr,
  input  logic        rd,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [4:0]  vec,
  input  logic        ack,
  input  logic        rti
);

  localparam logic [NSRC-1:0] ONE = NSRC'(1'b1);

  function automatic logic [4:0] first_set(input logic [NSRC-1:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  function automatic logic [31:0] widen(input logic [NSRC-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[NSRC-1:0] = v;
    return r;
  endfunction

  logic [NSRC-1:0] sync_r [SYNC];
  logic [NSRC-1:0] s_prev_r, pend_r, enb_r, mode_r, insvc_r;
  logic            irq_r;
  logic [4:0]      vec_r;

  logic [NSRC-1:0] s_s, edge_s, pend_s, insvc_low_s, ceil_s, elig_s;
  logic [NSRC-1:0] ack_mask_s, w1c_s, rti_mask_s, pend_next_s, insvc_next_s;
  logic            ack_hit_s;
  logic            wdata_unused_s;

  assign wdata_unused_s = ^wdata;

  // Source synchroniser chain and edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC; i++) sync_r[i] <= '0;
      s_prev_r <= '0;
    end else begin
      sync_r[0] <= src;
      for (int i = 1; i < SYNC; i++) sync_r[i] <= sync_r[i-1];
      s_prev_r <= s_s;
    end
  end

  assign s_s    = sync_r[SYNC-1];
  assign edge_s = s_s & ~s_prev_r;

  // Level channels expose the synchronised input directly; edge channels use the latch
  always_comb begin
    pend_s      = (mode_r & pend_r) | (~mode_r & s_s);
    insvc_low_s = insvc_r & (~insvc_r + ONE);
    if (insvc_r == '0) begin
      ceil_s = '1;
    end else if (NEST != 0) begin
      ceil_s = insvc_low_s - ONE;
    end else begin
      ceil_s = '0;
    end
    elig_s = pend_s & enb_r & ceil_s;
  end

  // Acknowledge, write-1-clear and return-from-interrupt masks, next-state for latches
  always_comb begin
    ack_hit_s = ack & irq_r;
    if (ack_hit_s) begin
      ack_mask_s = ONE << vec_r;
    end else begin
      ack_mask_s = '0;
    end
    if (wr && (ioadr == 3'd0)) begin
      w1c_s = wdata[NSRC-1:0];
    end else begin
      w1c_s = '0;
    end
    if (rti) begin
      rti_mask_s = insvc_low_s;
    end else begin
      rti_mask_s = '0;
    end
    // a fresh edge beats any clear arriving in the same cycle
    pend_next_s  = mode_r & (edge_s | (pend_r & ~(ack_mask_s | w1c_s)));
    insvc_next_s = (insvc_r & ~rti_mask_s) | ack_mask_s;
  end

  // Channel state and configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r  <= '0;
      insvc_r <= '0;
      enb_r   <= '0;
      mode_r  <= MODE_RST;
    end else begin
      pend_r  <= pend_next_s;
      insvc_r <= insvc_next_s;
      if (wr && (ioadr == 3'd1)) enb_r <= wdata[NSRC-1:0];
      if (wr && (ioadr == 3'd2)) mode_r <= wdata[NSRC-1:0];
    end
  end

  // Registered request and vector towards the CPU; vector holds when nothing is eligible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_r <= 1'b0;
      vec_r <= 5'd0;
    end else begin
      irq_r <= |elig_s;
      if (elig_s != '0) vec_r <= first_set(elig_s);
    end
  end

  assign irq = irq_r;
  assign vec = vec_r;

  // Register read mux
  always_comb begin
    rdata = 32'd0;
    if (rd) begin
      case (ioadr)
        3'd0:    rdata = widen(pend_s);
        3'd1:    rdata = widen(enb_r);
        3'd2:    rdata = widen(mode_r);
        3'd3:    rdata = widen(insvc_r);
        3'd4:    rdata = {27'd0, vec_r};
        default: rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic, checked against a
// channel-by-channel behavioural model that keeps its own delay line and in-service set.
module tb_irq_ctrl;
  localparam int NSRC = 8;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NSRC-1:0] src;
  logic [2:0]  ioadr;
  logic        wr, rd, ack, rti;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic [4:0]  vec;

  int vectors = 0;
  int miscompares = 0;

  irq_ctrl #(.NSRC(NSRC), .SYNC(SYNC), .NEST(1), .MODE_RST(8'hFF)) dut (
    .clk(clk), .rst(rst), .src(src), .ioadr(ioadr), .wr(wr), .rd(rd),
    .wdata(wdata), .rdata(rdata), .irq(irq), .vec(vec), .ack(ack), .rti(rti)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit [NSRC-1:0] q[$];
  bit [NSRC-1:0] m_sprev, m_pend, m_enb, m_mode, m_insvc;
  bit            m_irq;
  int            m_vec;

  function automatic int lowest(input bit [NSRC-1:0] v);
    for (int i = 0; i < NSRC; i++) if (v[i]) return i;
    return NSRC;
  endfunction

  task automatic model_reset();
    q = {};
    repeat (SYNC) q.push_back('0);
    m_sprev = '0; m_pend = '0; m_enb = '0; m_mode = '1; m_insvc = '0;
    m_irq = 1'b0; m_vec = 0;
  endtask

  task automatic model_step();
    bit [NSRC-1:0] s, np, ni, ne, nm;
    int  lo, first;
    bit  ack_ok, p, clr;
    s = q[0];
    lo = lowest(m_insvc);
    first = -1;
    for (int c = 0; c < NSRC; c++) begin
      p = m_mode[c] ? m_pend[c] : s[c];
      if (p && m_enb[c] && c < lo && first < 0) first = c;
    end
    ack_ok = ack && m_irq;
    for (int c = 0; c < NSRC; c++) begin
      clr = (ack_ok && m_vec == c) || (wr && ioadr == 3'd0 && wdata[c]);
      np[c] = m_mode[c] && ((s[c] && !m_sprev[c]) || (m_pend[c] && !clr));
    end
    ni = m_insvc;
    if (rti && lo < NSRC) ni[lo] = 1'b0;
    if (ack_ok) ni[m_vec] = 1'b1;
    ne = (wr && ioadr == 3'd1) ? wdata[NSRC-1:0] : m_enb;
    nm = (wr && ioadr == 3'd2) ? wdata[NSRC-1:0] : m_mode;
    m_pend = np; m_insvc = ni; m_enb = ne; m_mode = nm;
    m_irq = (first >= 0);
    if (first >= 0) m_vec = first;
    m_sprev = s;
    q.push_back(src);
    void'(q.pop_front());
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a, input logic r);
    logic [31:0] v;
    bit [NSRC-1:0] s;
    v = 32'd0;
    s = q[0];
    if (r) begin
      case (a)
        3'd0: for (int c = 0; c < NSRC; c++) v[c] = m_mode[c] ? m_pend[c] : s[c];
        3'd1: v[NSRC-1:0] = m_enb;
        3'd2: v[NSRC-1:0] = m_mode;
        3'd3: v[NSRC-1:0] = m_insvc;
        3'd4: v = 32'(m_vec);
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("irq", 32'(irq), 32'(m_irq));
    check("vec", 32'(vec), 32'(m_vec));
    check("rdata", rdata, model_read(ioadr, rd));
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
    ioadr = a; rd = 1'b1;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    ioadr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src = '0; ioadr = 3'd0; wr = 1'b0; rd = 1'b0;
    wdata = 32'd0; ack = 1'b0; rti = 1'b0;
    model_reset();
    #12;
    rst = 1'b0;
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_vec", 32'(vec), 32'd0);
    rd_chk(3'd2, 32'h0000_00FF, "rst_mode");

    // Basic edge with latency SYNC+2
    wr_reg(3'd1, 32'h04);
    src[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lat_irq_low", 32'(irq), 32'd0);
    end
    src[2] = 1'b0;
    tick();
    check("lat_irq", 32'(irq), 32'd1);
    check("lat_vec", 32'(vec), 32'd2);
    ack = 1'b1; tick(); ack = 1'b0;
    rd_chk(3'd3, 32'h04, "ack_insvc");
    rd_chk(3'd0, 32'h00, "ack_pend");
    tick();
    check("ack_irq_drop", 32'(irq), 32'd0);
    rti = 1'b1; tick(); rti = 1'b0;
    rd_chk(3'd3, 32'h00, "rti_insvc");

    // Priority: 1 beats 5, 5 waits for rti
    wr_reg(3'd1, 32'hFF);
    src[5] = 1'b1; src[1] = 1'b1;
    repeat (3) tick();
    src = '0;
    tick();
    check("prio_vec", 32'(vec), 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    tick();
    check("prio_blocked", 32'(irq), 32'd0);
    rti = 1'b1; tick(); rti = 1'b0;
    tick();
    check("prio_next_irq", 32'(irq), 32'd1);
    check("prio_next_vec", 32'(vec), 32'd5);
    ack = 1'b1; tick(); ack = 1'b0;
    rti = 1'b1; tick(); rti = 1'b0;
    tick();

    // Nesting: 3 preempts 6
    src[6] = 1'b1;
    repeat (3) tick();
    src = '0;
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    rd_chk(3'd3, 32'h40, "nest_insvc6");
    src[3] = 1'b1;
    repeat (3) tick();
    src = '0;
    tick();
    check("nest_irq", 32'(irq), 32'd1);
    check("nest_vec", 32'(vec), 32'd3);
    ack = 1'b1; tick(); ack = 1'b0;
    rd_chk(3'd3, 32'h48, "nest_insvc48");
    rti = 1'b1; tick(); rti = 1'b0;
    rd_chk(3'd3, 32'h40, "nest_rti1");
    rti = 1'b1; tick(); rti = 1'b0;
    rd_chk(3'd3, 32'h00, "nest_rti2");

    // Level channel 0 re-requests after rti
    wr_reg(3'd2, 32'hFE);
    src[0] = 1'b1;
    wr_reg(3'd1, 32'h01);
    repeat (4) tick();
    check("lvl_irq", 32'(irq), 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    tick();
    check("lvl_held", 32'(irq), 32'd0);
    rti = 1'b1; tick(); rti = 1'b0;
    check("lvl_rti_edge", 32'(irq), 32'd0);
    tick();
    check("lvl_rereq", 32'(irq), 32'd1);
    wr_reg(3'd0, 32'h01);
    rd_chk(3'd0, 32'h01, "lvl_w1c_ignored");
    // Edge on channel 1 coinciding with its write-1-clear
    src[1] = 1'b1;
    tick(); tick();
    ioadr = 3'd0; wdata = 32'h02; wr = 1'b1; tick(); wr = 1'b0;
    rd_chk(3'd0, 32'h03, "set_wins");

    // Register access
    wr_reg(3'd1, 32'hFFFF_FFFF);
    rd_chk(3'd1, 32'h0000_00FF, "enb_width");
    rd_chk(3'd5, 32'd0, "adr5");
    rd_chk(3'd6, 32'd0, "adr6");
    rd_chk(3'd7, 32'd0, "adr7");
    ioadr = 3'd1; rd = 1'b0; #1;
    check("rd_low", rdata, 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NSRC; c++) if ($urandom_range(7) == 0) src[c] = ~src[c];
      wr = ($urandom_range(7) == 0);
      ioadr = 3'($urandom_range(7));
      wdata = $urandom;
      rd = 1'($urandom_range(1));
      ack = ($urandom_range(3) == 0);
      rti = ($urandom_range(7) == 0);
      tick();
    end
    wr = 1'b0; ack = 1'b0; rti = 1'b0; src = '0;

    // Bring to a known state, then reset in the middle of service
    wr_reg(3'd2, 32'hFF);
    wr_reg(3'd1, 32'hFF);
    rti = 1'b1; repeat (NSRC) tick(); rti = 1'b0;
    wr_reg(3'd0, 32'hFF);
    tick();
    src[1] = 1'b1;
    repeat (3) tick();
    src = '0;
    tick();
    check("pre_rst_vec1", 32'(vec), 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    src[0] = 1'b1;
    repeat (4) tick();
    check("pre_rst_irq", 32'(irq), 32'd1);
    rd_chk(3'd3, 32'h02, "pre_rst_insvc");
    #1 rst = 1'b1;
    model_reset();
    #1;
    check("arst_irq", 32'(irq), 32'd0);
    check("arst_vec", 32'(vec), 32'd0);
    @(posedge clk);
    #1;
    rd_chk(3'd0, 32'h00, "arst_pend");
    rd_chk(3'd1, 32'h00, "arst_enb");
    rd_chk(3'd2, 32'hFF, "arst_mode");
    rd_chk(3'd3, 32'h00, "arst_insvc");
    rst = 1'b0; src = '0;
    ack = 1'b1; tick(); ack = 1'b0;
    rd_chk(3'd3, 32'h00, "ack_idle_insvc");
    check("ack_idle_irq", 32'(irq), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
